// File: rtl/fp_mul_arbiter_if.sv
// Request/response bundle between the client blocks and fp_mul_arbiter.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; valid may drop before ready.
interface fp_mul_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one external combinational FP multiplier between NUM_REQ requesters.
// Operands are registered, held MUL_LATENCY cycles, then the product is returned with the requester id.
module fp_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  fp_mul_arbiter_if.slave  bus,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [31:0]      mul_result,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant;
  logic               found;
  logic [NUM_REQ-1:0] ready;
  logic [3:0]         wait_cnt;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [31:0]        rsp_result_q;
  int                 idx;

  // Scan from the highest offset down so the last hit is the first requester at or after ptr.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req_valid[idx]) begin
        found = 1'b1;
        grant = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    ready   = '0;
    case (state)
      IDLE: begin
        if (found) begin
          ready[grant] = 1'b1;
          state_n      = WAIT;
        end
      end
      WAIT:    if (wait_cnt == 4'd1) state_n = RESP;
      RESP:    if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      wait_cnt     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      op_count     <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (found) begin
            mul_a    <= bus.req_a[grant*32 +: 32];
            mul_b    <= bus.req_b[grant*32 +: 32];
            rsp_id_q <= grant;
            ptr      <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + ID_W'(1);
            wait_cnt <= 4'(MUL_LATENCY);
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            rsp_result_q <= mul_result;
            rsp_valid_q  <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count    <= op_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign busy           = (state != IDLE);
  assign dbg_state      = state;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: directed vectors, corner sequences and random traffic against a cycle-level model.
module tb_fp_mul_arbiter;
  localparam int NUM = 4;
  localparam int LAT = 4;
  localparam int CW  = 4;

  logic          clk;
  logic          rst;
  logic [31:0]   mul_a, mul_b, mul_result;
  logic          busy;
  logic [CW-1:0] op_count;
  logic [1:0]    dbg_state;

  fp_mul_arbiter_if #(.NUM_REQ(NUM)) bus ();

  fp_mul_arbiter #(.NUM_REQ(NUM), .MUL_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
  );

  // External multiplier: IEEE single multiply, round-to-nearest-even, zero/denormal inputs flushed.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s; int e; logic [47:0] p; logic [22:0] m; logic g, st; logic [23:0] r;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin m = p[46:24]; g = p[23]; st = |p[22:0]; e++; end
    else       begin m = p[45:23]; g = p[22]; st = |p[21:0]; end
    r = {1'b0, m};
    if (g && (st || m[0])) r = r + 24'd1;
    if (r[23]) e++;
    return {s, e[7:0], r[22:0]};
  endfunction

  assign mul_result = fmul(mul_a, mul_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic auto_drop = 1'b0;
  logic [NUM-1:0] last_acc;

  // Reference model state
  logic        m_busy;
  int          m_ptr, m_cnt, m_acc_cyc;
  logic [31:0] m_mul_a, m_mul_b;
  logic [31:0] exp_q[$];
  int          id_q[$];
  int          rsp_log[$];
  logic [31:0] res_log[$];
  int          rdy_cnt[NUM];

  typedef struct { int id; logic [31:0] a; logic [31:0] b; logic [31:0] res; } vec_t;
  vec_t vecs[6];
  vec_t quad[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NUM-1:0] v, input int p);
    for (int k = 0; k < NUM; k++)
      if (v[(p + k) % NUM]) return (p + k) % NUM;
    return -1;
  endfunction

  task automatic sample();
    logic [NUM-1:0] exp_rdy;
    int g;
    logic exp_rv;
    if (rst) begin
      m_busy = 1'b0; m_ptr = 0; m_cnt = 0; m_acc_cyc = 0;
      m_mul_a = '0; m_mul_b = '0;
      exp_q.delete(); id_q.delete(); rsp_log.delete(); res_log.delete();
      for (int i = 0; i < NUM; i++) rdy_cnt[i] = 0;
      last_acc = '0;
      return;
    end
    exp_rdy = '0;
    g = m_busy ? -1 : rr_pick(bus.req_valid, m_ptr);
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_rv = m_busy && (cyc - m_acc_cyc >= LAT + 1);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("op_count", 32'(op_count), 32'(m_cnt));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    chk("mul_a", mul_a, m_mul_a);
    chk("mul_b", mul_b, m_mul_b);
    if (exp_rv) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(id_q[0]));
      chk("rsp_result", bus.rsp_result, exp_q[0]);
    end
    for (int i = 0; i < NUM; i++) if (bus.req_ready[i]) rdy_cnt[i]++;
    last_acc = bus.req_valid & bus.req_ready;
    if (g >= 0) begin
      m_mul_a = bus.req_a[g*32 +: 32];
      m_mul_b = bus.req_b[g*32 +: 32];
      exp_q.push_back(fmul(m_mul_a, m_mul_b));
      id_q.push_back(g);
      m_busy = 1'b1;
      m_acc_cyc = cyc;
      m_ptr = (g + 1) % NUM;
    end else if (exp_rv && bus.rsp_ready) begin
      rsp_log.push_back(int'(bus.rsp_id));
      res_log.push_back(bus.rsp_result);
      void'(exp_q.pop_front());
      void'(id_q.pop_front());
      m_busy = 1'b0;
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
    if (auto_drop) bus.req_valid = bus.req_valid & ~last_acc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    while (rsp_log.size() < n && budget > 0) begin
      step();
      budget--;
    end
    chk("rsp_count", 32'(rsp_log.size()), 32'(n));
  endtask

  task automatic drain();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 40 && (m_busy || busy); i++) step();
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic load(input int id, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[id*32 +: 32] = a;
    bus.req_b[id*32 +: 32] = b;
  endtask

  initial begin
    vecs[0] = '{0, 32'h3FC00000, 32'h3FA00000, 32'h3FF00000};
    vecs[1] = '{1, 32'h42540000, 32'h42CC0000, 32'h45A8F000};
    vecs[2] = '{2, 32'hBFE00000, 32'h42C80000, 32'hC32F0000};
    vecs[3] = '{3, 32'hC1200000, 32'hC1A40000, 32'h434D0000};
    vecs[4] = '{2, 32'h00000000, 32'h40400000, 32'h00000000};
    vecs[5] = '{1, 32'h80000000, 32'h3F800000, 32'h80000000};
    quad[0] = '{0, 32'h42540000, 32'h42CC0000, 32'h45A8F000};
    quad[1] = '{1, 32'hBFE00000, 32'h42C80000, 32'hC32F0000};
    quad[2] = '{2, 32'hC1200000, 32'hC1A40000, 32'h434D0000};
    quad[3] = '{3, 32'h3FC00000, 32'h3FA00000, 32'h3FF00000};

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    last_acc = '0;
    do_reset();

    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // Reset two cycles into WAIT: no response, pointer back to 0
    auto_drop = 1'b1;
    bus.rsp_ready = 1'b1;
    load(2, 32'h3FC00000, 32'h3FA00000);
    bus.req_valid = 4'b0100;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midwait_busy", 32'(busy), 32'd0);
    chk("midwait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midwait_op_count", 32'(op_count), 32'd0);
    load(0, 32'h3FC00000, 32'h3FA00000);
    load(3, 32'h42540000, 32'h42CC0000);
    bus.req_valid = 4'b1001;
    wait_rsp(1, 40);
    chk("midwait_grant", 32'(rsp_log[0]), 32'd0);
    chk("midwait_result", res_log[0], 32'h3FF00000);
    chk("midwait_cnt", 32'(op_count), 32'd1);
    drain();

    // Directed single-request vectors
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      load(vecs[k].id, vecs[k].a, vecs[k].b);
      bus.req_valid = 4'(1 << vecs[k].id);
      wait_rsp(k + 1, 40);
      chk($sformatf("vec%0d_id", k), 32'(rsp_log[k]), 32'(vecs[k].id));
      chk($sformatf("vec%0d_res", k), res_log[k], vecs[k].res);
      chk($sformatf("vec%0d_cnt", k), 32'(op_count), 32'(k + 1));
    end
    drain();

    // All four at once from ptr=0
    do_reset();
    for (int k = 0; k < 4; k++) load(quad[k].id, quad[k].a, quad[k].b);
    bus.req_valid = 4'hF;
    wait_rsp(4, 200);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("quad%0d_id", k), 32'(rsp_log[k]), 32'(quad[k].id));
      chk($sformatf("quad%0d_res", k), res_log[k], quad[k].res);
      chk($sformatf("quad%0d_ready_pulses", k), 32'(rdy_cnt[k]), 32'd1);
    end
    drain();

    // Back-pressure in RESP
    auto_drop = 1'b0;
    bus.rsp_ready = 1'b0;
    load(1, 32'h3FC00000, 32'h3FA00000);
    bus.req_valid = 4'b0010;
    for (int i = 0; i < 40 && !bus.rsp_valid; i++) step();
    begin
      int base;
      base = m_cnt;
      for (int i = 0; i < 10; i++) begin
        step();
        chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_id", 32'(bus.rsp_id), 32'd1);
        chk("bp_result", bus.rsp_result, 32'h3FF00000);
        chk("bp_ready", 32'(bus.req_ready), 32'd0);
        chk("bp_cnt", 32'(op_count), 32'(base));
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      step();
      chk("bp_release_cnt", 32'(op_count), 32'((base + 1) % (1 << CW)));
    end
    drain();

    // Fairness with req0 and req2 held continuously
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0101;
    wait_rsp(6, 200);
    for (int k = 0; k < 6; k++)
      chk($sformatf("fair%0d", k), 32'(rsp_log[k]), 32'((k % 2) * 2));
    drain();

    // Counter wrap: 17 completions in a 4-bit counter
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0010;
    wait_rsp(17, 400);
    bus.req_valid = '0;
    chk("wrap_cnt", 32'(op_count), 32'd1);
    drain();

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      for (int r = 0; r < NUM; r++) load(r, rand_fp(), rand_fp());
      bus.req_valid = 4'($urandom_range(0, 15));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 150) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one combinational FP_Multiplication instance (IEEE-754 single precision) between NUM_REQ requesters.
- Each requester has a valid/ready request channel. Arbitration is round-robin.
- The block drives the multiplier operands from registers and waits a configurable settle time. It then returns the registered product on a shared response channel tagged with the requester ID.
- It sits between the client blocks and the multiplier. The multiplier is external, connected through the mul_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MUL_LATENCY, 1, clock cycles the operand registers are held before the product is sampled (1..15).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  NUM_REQ*32  packed operand A; requester i uses bits [32i+31:32i].
- req_b  in  NUM_REQ*32  packed operand B, same packing.
- mul_a  out  32  operand A to the multiplier (registered).
- mul_b  out  32  operand B to the multiplier (registered).
- mul_result  in  32  product from the multiplier.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns the response.
- rsp_result  out  32  registered product.
- busy  out  1  high whenever state != IDLE.
- op_count  out  CNT_W  number of completed responses; wraps to 0.

Behaviour:
- Reset values: state=IDLE, ptr=0, mul_a=mul_b=0, rsp_valid=0, rsp_id=0, rsp_result=0, op_count=0, busy=0, req_ready=0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready[grant]=1 combinationally; all other bits 0. req_ready=0 when no request is valid.
  - On the accept edge: mul_a/mul_b <= the granted operands, rsp_id <= grant, ptr <= (grant+1) mod NUM_REQ, wait_cnt <= MUL_LATENCY, go to WAIT.
- WAIT:
  - req_ready=0. wait_cnt decrements each edge.
  - On the edge where wait_cnt==1: rsp_result <= mul_result, rsp_valid <= 1, go to RESP.
  - Net effect: rsp_valid rises exactly MUL_LATENCY edges after the accept edge.
- RESP:
  - rsp_valid, rsp_id and rsp_result are held stable until rsp_ready=1.
  - On an edge with rsp_ready=1: rsp_valid <= 0, op_count <= op_count+1 (wrapping at 2^CNT_W), go to IDLE.
  - No new request is accepted in the same cycle. Minimum issue interval is MUL_LATENCY+2 cycles.
- mul_a/mul_b keep their last values outside WAIT. They are not cleared after an operation.
- Requesters may drop req_valid before it is granted. Only the valid/ready handshake cycle counts as acceptance.
- Operands are captured once at acceptance. Changes to req_a/req_b after acceptance have no effect.
- Starvation-free: a requester holding req_valid continuously is granted within NUM_REQ grants.
- rst asserted in any state, including mid-WAIT or RESP with rsp_valid=1:
  - all registers return to their reset values on the next edge;
  - the in-flight operation is dropped with no response and op_count is not incremented.
- rsp_ready while rsp_valid=0 is ignored.
- The block does no arithmetic on the data and does not inspect or modify special values (zero, inf, NaN). The product passes through bit-exact.

Test Plan:
- Single requester 0: a=0x3FC00000 (1.5), b=0x3FA00000 (1.25), rsp_ready=1 -> rsp_valid 1 edge after accept (MUL_LATENCY=1), rsp_id=0, rsp_result=0x3FF00000, op_count=1.
- All four requesters valid at once, ptr=0:
  - operands: req0 53×102, req1 -1.75×100, req2 -10×-20.5, req3 1.5×1.25;
  - required order of responses: id 0,1,2,3;
  - required results: 0x45A8F000, 0xC32F0000, 0x434D0000, 0x3FF00000;
  - each requester's req_ready pulses exactly once.
- Back-pressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid/rsp_id/rsp_result stable, req_ready stays 0 with req_valid high, op_count unchanged; release -> op_count increments by 1.
- Fairness: req0 and req2 held valid continuously for 6 grants -> grant order 0,2,0,2,0,2.
- Reset mid-WAIT with MUL_LATENCY=4, rst asserted 2 cycles after accept -> no rsp_valid, busy=0, ptr=0, op_count unchanged. The next request completes normally.
- Counter wrap: CNT_W=4, 17 completed operations -> op_count reads 1.
